// File: rtl/psum_row_collector.sv
// Gathers one psum beat per lane from the last PE row and serialises them lane 0..N-1 onto one stream.
// Latency 2 cycles from lane handshake to m_axis_tvalid; a full lane buffer stalls only that lane, output holds under backpressure.
module psum_row_collector #(
  parameter int PE_NUMBER_I = 4,
  parameter int PSUM_WIDTH  = 32,
  parameter int ID_WIDTH    = (PE_NUMBER_I > 1) ? $clog2(PE_NUMBER_I) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PE_NUMBER_I*PSUM_WIDTH-1:0] s_axis_d_tdata,
  input  logic [PE_NUMBER_I-1:0]            s_axis_d_tvalid,
  output logic [PE_NUMBER_I-1:0]            s_axis_d_tready,
  input  logic [PE_NUMBER_I-1:0]            s_axis_d_tlast,
  output logic [PSUM_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [ID_WIDTH-1:0]               m_axis_tid,
  output logic                              err_unalligned_data
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(PE_NUMBER_I - 1);

  logic [PE_NUMBER_I-1:0][PSUM_WIDTH-1:0] buf_data;
  logic [PE_NUMBER_I-1:0]                 buf_last;
  logic [PE_NUMBER_I-1:0]                 buf_full;
  logic [PE_NUMBER_I-1:0]                 lane_hs;

  logic [ID_WIDTH-1:0]   idx;
  logic [ID_WIDTH-1:0]   idx_nxt;
  logic [PSUM_WIDTH-1:0] out_data;
  logic [ID_WIDTH-1:0]   out_id;
  logic                  out_valid;
  logic                  row_last;
  logic                  err;
  logic                  load;

  assign s_axis_d_tready = ~buf_full & {PE_NUMBER_I{~rst}};
  assign lane_hs         = s_axis_d_tvalid & s_axis_d_tready;

  assign load    = buf_full[idx] && (!out_valid || m_axis_tready);
  assign idx_nxt = (idx == LAST_ID) ? '0 : idx + ID_WIDTH'(1);

  // Capture and drain never coincide on one lane: capture needs an empty slot, drain a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= '0;
    end else begin
      for (int i = 0; i < PE_NUMBER_I; i++) begin
        if (lane_hs[i]) begin
          buf_full[i] <= 1'b1;
        end else if (load && idx == ID_WIDTH'(i)) begin
          buf_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PE_NUMBER_I; i++) begin
      if (lane_hs[i]) begin
        buf_data[i] <= s_axis_d_tdata[i*PSUM_WIDTH +: PSUM_WIDTH];
        buf_last[i] <= s_axis_d_tlast[i];
      end
    end
  end

  // Lane 0 sets the row's tlast; every later lane of the row is compared against it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      row_last  <= 1'b0;
      err       <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= buf_data[idx];
      out_id    <= idx;
      idx       <= idx_nxt;
      if (idx == '0) begin
        row_last <= buf_last[0];
      end else if (buf_last[idx] != row_last) begin
        err <= 1'b1;
      end
    end else if (m_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign m_axis_tvalid       = out_valid && !rst;
  assign m_axis_tdata        = rst ? '0 : out_data;
  assign m_axis_tid          = rst ? '0 : out_id;
  assign m_axis_tlast        = !rst && row_last && (out_id == LAST_ID);
  assign err_unalligned_data = err && !rst;

endmodule

// File: tb/tb_psum_row_collector.sv
// Scoreboard bench for psum_row_collector: a 4-lane instance for ordering, backpressure, tlast and reset,
// plus a 1-lane instance for the degenerate single-column case.
module tb_psum_row_collector;

  typedef struct packed { logic [31:0] d; logic [1:0] id; logic l; logic e; } exp_t;
  typedef struct packed { logic [31:0] d; logic l; } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] s_data;
  logic [3:0]   s_valid, s_ready, s_last;
  logic [31:0]  m_data;
  logic         m_valid, m_ready, m_last, m_err;
  logic [1:0]   m_tid;

  logic [31:0]  d1_data;
  logic [0:0]   d1_valid, d1_ready, d1_last, m1_tid;
  logic [31:0]  m1_data;
  logic         m1_valid, m1_ready, m1_last, m1_err;

  exp_t  sb[$];
  exp_t  sb1[$];
  beat_t lane_q[4][$];
  beat_t q1[$];

  int   vec_cnt = 0;
  int   miss_cnt = 0;
  int   cyc = 0;
  int   outs1 = 0;
  int   last1_cyc = -1;
  logic errm = 1'b0;
  logic tog_en = 1'b0;
  logic m_rdy_cfg = 1'b1;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [1:0]  prev_id;

  psum_row_collector #(.PE_NUMBER_I(4), .PSUM_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axis_d_tdata(s_data), .s_axis_d_tvalid(s_valid), .s_axis_d_tready(s_ready), .s_axis_d_tlast(s_last),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
    .m_axis_tid(m_tid), .err_unalligned_data(m_err)
  );

  psum_row_collector #(.PE_NUMBER_I(1), .PSUM_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_d_tdata(d1_data), .s_axis_d_tvalid(d1_valid), .s_axis_d_tready(d1_ready), .s_axis_d_tlast(d1_last),
    .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready), .m_axis_tlast(m1_last),
    .m_axis_tid(m1_tid), .err_unalligned_data(m1_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Single driver for all DUT inputs except rst: handshakes seen at the negedge retire queue heads.
  initial begin : driver
    logic [3:0] hs;
    logic       hs1;
    s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b1;
    d1_valid = '0; d1_data = '0; d1_last = '0; m1_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs  = s_valid & s_ready;
      hs1 = d1_valid[0] & d1_ready[0];
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) void'(lane_q[i].pop_front());
        if (lane_q[i].size() > 0) begin
          s_valid[i]          = 1'b1;
          s_data[i*32 +: 32]  = lane_q[i][0].d;
          s_last[i]           = lane_q[i][0].l;
        end else begin
          s_valid[i] = 1'b0;
        end
      end
      if (hs1) void'(q1.pop_front());
      if (q1.size() > 0) begin
        d1_valid = 1'b1; d1_data = q1[0].d; d1_last = q1[0].l;
      end else begin
        d1_valid = 1'b0;
      end
      m_ready = tog_en ? ~m_ready : m_rdy_cfg;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_vld", 64'(m_valid), 64'd1);
        chk("hold_dat", 64'(m_data), 64'(prev_d));
        chk("hold_tid", 64'(m_tid), 64'(prev_id));
      end
      if (m_valid && m_ready) begin
        chk("extra_beat", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("tdata", 64'(m_data), 64'(e.d));
          chk("tid", 64'(m_tid), 64'(e.id));
          chk("tlast", 64'(m_last), 64'(e.l));
          chk("err", 64'(m_err), 64'(e.e));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_id    = m_tid;
      if (m1_valid && m1_ready) begin
        chk("n1_extra", 64'(sb1.size() != 0), 64'd1);
        if (last1_cyc >= 0) chk("n1_gap_ge2", 64'(cyc - last1_cyc >= 2), 64'd1);
        last1_cyc = cyc;
        outs1++;
        if (sb1.size() != 0) begin
          e = sb1.pop_front();
          chk("n1_tdata", 64'(m1_data), 64'(e.d));
          chk("n1_tid", 64'(m1_tid), 64'd0);
          chk("n1_tlast", 64'(m1_last), 64'(e.l));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] base, input logic [3:0] lasts, input int i);
    exp_t e;
    if (i != 0 && lasts[i] != lasts[0]) errm = 1'b1;
    e.d = base + 32'(i); e.id = 2'(i); e.l = lasts[0] && (i == 3); e.e = errm;
    sb.push_back(e);
  endtask

  task automatic send_row(input logic [31:0] base, input logic [3:0] lasts);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      push_exp(base, lasts, i);
      b.d = base + 32'(i); b.l = lasts[i];
      lane_q[i].push_back(b);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin : main
    beat_t b;
    exp_t  e;
    int    hs_c, v_c, n;

    // Reset state
    step(1);
    @(negedge clk);
    chk("rst_tvalid", 64'(m_valid), 64'd0);
    chk("rst_tready", 64'(s_ready), 64'd0);
    chk("rst_tdata", 64'(m_data), 64'd0);
    chk("rst_err", 64'(m_err), 64'd0);
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", 64'(s_ready), 64'hF);
    chk("idle_tvalid", 64'(m_valid), 64'd0);
    chk("idle_tlast", 64'(m_last), 64'd0);

    // 1: full row together, latency lane handshake -> tvalid
    step(1);
    send_row(32'd10, 4'b1111);
    hs_c = -1; v_c = -1; n = 0;
    while ((hs_c < 0 || v_c < 0) && n < 20) begin
      @(negedge clk);
      if (hs_c < 0 && s_valid[0] && s_ready[0]) hs_c = cyc;
      if (v_c < 0 && m_valid) v_c = cyc;
      n++;
    end
    chk("latency", 64'(v_c - hs_c), 64'd2);
    wait_drain("t1_drain", 30);

    // 2: lanes arrive 3,2,1,0; output order still 0..3
    step(1);
    for (int i = 0; i < 4; i++) push_exp(32'hA00, 4'b1111, i);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) begin
        @(negedge clk);
        chk("stag_l3_held", 64'(s_ready[3]), 64'd0);
        step(1);
      end
      b.d = 32'hA00 + 32'(i); b.l = 1'b1;
      lane_q[i].push_back(b);
      step(1);
    end
    wait_drain("t2_drain", 40);

    // 3: back-to-back rows with toggling m_tready
    step(1);
    tog_en = 1'b1;
    for (int r = 0; r < 4; r++)
      send_row(($urandom & 32'hFFFF_FF00) | 32'(r << 4), (r == 3) ? 4'b1111 : 4'b0000);
    wait_drain("t3_drain", 200);
    tog_en = 1'b0;
    m_rdy_cfg = 1'b1;
    step(2);
    chk("t3_no_err", 64'(m_err), 64'd0);

    // 4: misaligned tlast on lane 2 only, then a clean row
    send_row(32'hB00, 4'b0100);
    send_row(32'hC00, 4'b1111);
    wait_drain("t4_drain", 60);
    step(2);
    chk("t4_err_sticky", 64'(m_err), 64'd1);

    // 5: reset with lanes 0,1 delivered and lanes 2,3 still inside
    for (int i = 0; i < 2; i++) begin
      push_exp(32'hD00, 4'b1111, i);
      b.d = 32'hD00 + 32'(i); b.l = 1'b1;
      lane_q[i].push_back(b);
    end
    wait_drain("t5_first", 30);
    m_rdy_cfg = 1'b0;
    step(2);
    for (int i = 2; i < 4; i++) begin
      b.d = 32'hD00 + 32'(i); b.l = 1'b1;
      lane_q[i].push_back(b);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((lane_q[2].size() != 0 || lane_q[3].size() != 0 || s_valid[3:2] != 2'b00) && n < 30);
    chk("t5_sent", 64'(lane_q[2].size() + lane_q[3].size()), 64'd0);
    step(2);
    @(negedge clk);
    chk("t5_stalled_tid", 64'(m_tid), 64'd2);
    step(1);
    rst = 1'b1;
    errm = 1'b0;
    @(negedge clk);
    chk("t5_rst_tvalid", 64'(m_valid), 64'd0);
    chk("t5_rst_tready", 64'(s_ready), 64'd0);
    step(2);
    rst = 1'b0;
    m_rdy_cfg = 1'b1;
    @(negedge clk);
    chk("t5_err_clr", 64'(m_err), 64'd0);
    chk("t5_tready", 64'(s_ready), 64'hF);
    step(1);
    send_row(32'hE00, 4'b1111);
    wait_drain("t5_drain", 40);
    step(4);
    chk("t5_no_stale", 64'(m_valid), 64'd0);

    // 6: single-lane instance, 8 beats
    for (int k = 0; k < 8; k++) begin
      b.d = 32'hF00 + 32'(k * 3); b.l = (k == 7);
      q1.push_back(b);
      e.d = b.d; e.id = 2'd0; e.l = b.l; e.e = 1'b0;
      sb1.push_back(e);
    end
    n = 0;
    while (sb1.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("n1_drain", 64'(sb1.size()), 64'd0);
    chk("n1_count", 64'(outs1), 64'd8);
    chk("n1_err", 64'(m1_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
